// File: rtl/fc_io_pkg.sv
// Shared types and sizing helpers for the fully-connected layer stream front/back end.
package fc_io_pkg;

   // Frame sequencing: collect activations, let the layer settle, stream results out.
   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_SETTLE = 2'd1,
      S_DRAIN  = 2'd2
   } fc_io_state_t;

   // Counter width for a counter that must reach n-1; never narrower than one bit.
   function automatic int fc_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Default layer geometry and the counter widths that go with it.
   localparam int FC_IN    = 128;
   localparam int FC_OUT   = 10;
   localparam int FC_IDX_W = $clog2(FC_IN);
   localparam int FC_O_W   = $clog2(FC_OUT);

endpackage

// File: rtl/fc_requant.sv
// Requantizes one wide neuron result to an activation: negative -> 0,
// otherwise truncating right shift with saturation to the all-ones code.
module fc_requant #(
   parameter int ZW    = 23,
   parameter int WIDTH = 8,
   parameter int SHIFT = 7
) (
   input  logic [ZW-1:0]    z_i,
   output logic [WIDTH-1:0] q_o
);

   localparam logic [ZW-1:0] Q_MAX = {{(ZW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

   logic [ZW-1:0] shifted;

   // Sign check first, then saturate the shifted magnitude.
   always_comb begin
      shifted = z_i >> SHIFT;
      if (z_i[ZW-1]) begin
         q_o = '0;
      end else if (shifted > Q_MAX) begin
         q_o = '1;
      end else begin
         q_o = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fc_stream_io.sv
// Serial activation collector and result streamer around a combinational FC layer.
// Handshakes: a beat transfers on a rising edge where valid && ready are both high;
// ready/valid outputs here depend only on registered state (and rst for s_ready),
// never on the partner's valid/ready, and m_data/m_last hold while m_valid && !m_ready.
module fc_stream_io
   import fc_io_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IN     = FC_IN,
   parameter int OUT    = FC_OUT,
   parameter int ZW     = WIDTH*2 + $clog2(IN),
   parameter int SHIFT  = 7,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_last,
   output logic [WIDTH-1:0] x [0:IN-1],
   input  logic [ZW-1:0]    z [0:OUT-1],
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy,
   output logic             frame_err
);

   localparam int IDX_W = (IN == FC_IN) ? FC_IDX_W : fc_cnt_w(IN);
   localparam int O_W   = (OUT == FC_OUT) ? FC_O_W : fc_cnt_w(OUT);
   localparam int SET_W = fc_cnt_w(SETTLE);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
   localparam logic [O_W-1:0]   O_LAST   = O_W'(OUT - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

   fc_io_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [O_W-1:0]   o_q, o_d;
   logic [SET_W-1:0] cnt_q, cnt_d;
   logic             frame_err_q, frame_err_d;
   logic [WIDTH-1:0] x_q   [0:IN-1];
   logic [WIDTH-1:0] zq_q  [0:OUT-1];
   logic [WIDTH-1:0] zq_rq [0:OUT-1];
   logic             s_fire, m_fire;
   logic             x_wr, x_clr, zq_cap;

   // One requantizer per neuron; all are captured together at the end of the settle window.
   for (genvar g = 0; g < OUT; g++) begin : g_rq
      fc_requant #(
         .ZW    (ZW),
         .WIDTH (WIDTH),
         .SHIFT (SHIFT)
      ) u_rq (
         .z_i (z[g]),
         .q_o (zq_rq[g])
      );
   end

   // Next-state, counter updates and handshake decode for the frame sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      o_d         = o_q;
      cnt_d       = cnt_q;
      frame_err_d = 1'b0;
      s_ready     = 1'b0;
      m_valid     = 1'b0;
      m_last      = 1'b0;
      s_fire      = 1'b0;
      m_fire      = 1'b0;
      x_wr        = 1'b0;
      x_clr       = 1'b0;
      zq_cap      = 1'b0;
      unique case (state_q)
         S_FILL: begin
            s_ready = !rst;
            s_fire  = s_valid && !rst;
            if (s_fire) begin
               x_wr  = 1'b1;
               idx_d = idx_q + 1'b1;
               if ((idx_q == IDX_LAST) || s_last) begin
                  state_d = S_SETTLE;
               end
               // s_last must coincide exactly with the final vector slot.
               frame_err_d = s_last ^ (idx_q == IDX_LAST);
            end
         end
         S_SETTLE: begin
            if (cnt_q == SET_LAST) begin
               cnt_d   = '0;
               zq_cap  = 1'b1;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            m_valid = 1'b1;
            m_last  = (o_q == O_LAST);
            m_fire  = m_ready;
            if (m_fire) begin
               if (o_q == O_LAST) begin
                  o_d     = '0;
                  idx_d   = '0;
                  x_clr   = 1'b1;
                  state_d = S_FILL;
               end else begin
                  o_d = o_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // State, counters and the framing-error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FILL;
         idx_q       <= '0;
         o_q         <= '0;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         o_q         <= o_d;
         cnt_q       <= cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Activation vector: written beat by beat, cleared when a frame's last result leaves.
   always_ff @(posedge clk) begin
      if (rst || x_clr) begin
         for (int i = 0; i < IN; i++) begin
            x_q[i] <= '0;
         end
      end else if (x_wr) begin
         x_q[idx_q] <= s_data;
      end
   end

   // Captured requantized results, loaded in the last settle cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OUT; i++) begin
            zq_q[i] <= '0;
         end
      end else if (zq_cap) begin
         zq_q <= zq_rq;
      end
   end

   assign x         = x_q;
   assign m_data    = zq_q[o_q];
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_FILL) || (idx_q != '0);

endmodule

// File: tb/tb_fc_stream_io.sv
// Randomized bench for fc_stream_io: drives frames, models the layer and the
// requantization arithmetically, and scores the output stream from a queue.
module tb_fc_stream_io;

   localparam int WIDTH  = 8;
   localparam int IN     = 128;
   localparam int OUT    = 10;
   localparam int ZW     = WIDTH*2 + $clog2(IN);
   localparam int SHIFT  = 7;
   localparam int SETTLE = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic             s_last;
   logic [WIDTH-1:0] x [0:IN-1];
   logic [ZW-1:0]    z [0:OUT-1];
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic             busy;
   logic             frame_err;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               exp_x [IN];
   int               w [OUT][IN];
   longint           z_stub [OUT];
   bit               use_stub;
   longint           acc;

   fc_stream_io #(
      .WIDTH  (WIDTH),
      .IN     (IN),
      .OUT    (OUT),
      .ZW     (ZW),
      .SHIFT  (SHIFT),
      .SETTLE (SETTLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .x         (x),
      .z         (z),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // Clock
   always #5 clk = ~clk;

   // Golden layer (dot products of x with the weights) or a fixed stub.
   always_comb begin
      acc = 0;
      for (int o = 0; o < OUT; o++) begin
         acc = 0;
         for (int i = 0; i < IN; i++) begin
            acc += longint'(x[i]) * w[o][i];
         end
         z[o] = use_stub ? z_stub[o][ZW-1:0] : acc[ZW-1:0];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference requantization from the arithmetic definition.
   function automatic logic [WIDTH-1:0] ref_requant(input longint zv);
      longint q;
      if (zv >= (longint'(1) << (ZW-1))) return '0;
      q = zv / (longint'(1) << SHIFT);
      if (q > (longint'(1) << WIDTH) - 1) return '1;
      return WIDTH'(q);
   endfunction

   function automatic int count_x_diff();
      int n;
      n = 0;
      for (int i = 0; i < IN; i++) begin
         if (x[i] !== WIDTH'(exp_x[i])) n++;
      end
      return n;
   endfunction

   task automatic clear_model_x();
      for (int i = 0; i < IN; i++) exp_x[i] = 0;
   endtask

   task automatic new_weights(input int wmax);
      for (int o = 0; o < OUT; o++)
         for (int i = 0; i < IN; i++)
            w[o][i] = $urandom_range(0, wmax);
   endtask

   // One frame: fill (s_last at last_pos; IN means never), settle, drain.
   // rst_after >= 0 pulses rst once that many results have been accepted.
   task automatic run_frame(input int last_pos, input int fixed_val, input int v_pct,
                            input int r_pct, input int rst_after);
      int         k, cyc, end_pos, n_out, lat;
      bit         err_exp, stalled;
      logic [WIDTH-1:0] held_d;
      logic       held_l;
      longint     zv;

      clear_model_x();
      end_pos = (last_pos < IN-1) ? last_pos : IN-1;
      err_exp = (last_pos != IN-1);
      k   = 0;
      cyc = 0;
      while (k <= end_pos && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         check_val("fill_s_ready", s_ready, 1);
         check_val("fill_m_valid", m_valid, 0);
         check_val("fill_frame_err", frame_err, 0);
         s_valid = ($urandom_range(0, 99) < v_pct);
         s_data  = (fixed_val >= 0) ? WIDTH'(fixed_val) : WIDTH'($urandom_range(0, 255));
         s_last  = (k == last_pos);
         if (s_valid) begin
            exp_x[k] = s_data;
            k++;
         end
      end
      if (cyc >= 4000) begin
         check_val("fill_timeout", 1, 0);
         return;
      end

      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat     = 1;
      check_val("frame_err_pulse", frame_err, err_exp);
      check_val("settle_s_ready", s_ready, 0);
      check_val("settle_busy", busy, 1);
      while (!m_valid && lat < 50) begin
         @(negedge clk);
         lat++;
         check_val("frame_err_single", frame_err, 0);
      end
      check_val("latency", lat, SETTLE + 1);
      check_val("x_vec", count_x_diff(), 0);

      exp_q.delete();
      for (int o = 0; o < OUT; o++) begin
         if (use_stub) begin
            zv = z_stub[o];
         end else begin
            zv = 0;
            for (int i = 0; i < IN; i++) zv += longint'(exp_x[i]) * w[o][i];
         end
         exp_q.push_back(ref_requant(zv));
      end

      n_out   = 0;
      stalled = 1'b0;
      held_d  = '0;
      held_l  = 1'b0;
      cyc     = 0;
      while (n_out < OUT && cyc < 1000) begin
         check_val("drain_m_valid", m_valid, 1);
         check_val("drain_s_ready", s_ready, 0);
         check_val("drain_busy", busy, 1);
         if (stalled) begin
            check_val("stall_data", m_data, held_d);
            check_val("stall_last", m_last, held_l);
         end
         if (rst_after >= 0 && n_out == rst_after) begin
            m_ready = 1'b0;
            rst     = 1'b1;
            @(negedge clk);
            clear_model_x();
            check_val("rst_m_valid", m_valid, 0);
            check_val("rst_s_ready", s_ready, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_x_clear", count_x_diff(), 0);
            rst = 1'b0;
            @(negedge clk);
            check_val("post_rst_s_ready", s_ready, 1);
            check_val("post_rst_m_valid", m_valid, 0);
            exp_q.delete();
            return;
         end
         m_ready = ($urandom_range(0, 99) < r_pct);
         if (m_ready) begin
            if (exp_q.size() > 0) check_val("m_data", m_data, exp_q.pop_front());
            check_val("m_last", m_last, (n_out == OUT-1));
            n_out++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held_d  = m_data;
            held_l  = m_last;
         end
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      check_val("drain_count", n_out, OUT);
      clear_model_x();
      check_val("post_m_valid", m_valid, 0);
      check_val("post_s_ready", s_ready, 1);
      check_val("post_busy", busy, 0);
      check_val("post_x_clear", count_x_diff(), 0);
   endtask

   // Stimulus sequence and final report.
   initial begin
      int lp;
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      use_stub = 1'b1;
      for (int o = 0; o < OUT; o++) z_stub[o] = 0;
      new_weights(0);
      clear_model_x();

      repeat (2) @(negedge clk);
      check_val("reset_s_ready", s_ready, 0);
      check_val("reset_m_valid", m_valid, 0);
      check_val("reset_m_last", m_last, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_frame_err", frame_err, 0);
      check_val("reset_x", count_x_diff(), 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("first_s_ready", s_ready, 1);

      // Nominal: all threes, stub z[o] = o*128 gives outputs 0..9.
      for (int o = 0; o < OUT; o++) z_stub[o] = o * 128;
      run_frame(IN-1, 3, 100, 100, -1);

      // Saturation, sign and truncation corners.
      z_stub[0] = 64'h3FFFFF;
      z_stub[1] = 64'h400000;
      z_stub[2] = 127;
      z_stub[3] = 128;
      for (int o = 4; o < OUT; o++) z_stub[o] = $urandom_range(0, (1 << (ZW-1)) - 1);
      run_frame(IN-1, -1, 70, 100, -1);

      // Golden layer with 30% downstream ready.
      use_stub = 1'b0;
      new_weights(3);
      run_frame(IN-1, -1, 100, 30, -1);

      // Early s_last on beat 5.
      new_weights(3);
      run_frame(5, -1, 100, 100, -1);

      // Missing s_last; the following frame must start at x[0].
      new_weights(1);
      run_frame(IN, -1, 100, 60, -1);
      new_weights(3);
      run_frame(IN-1, -1, 80, 50, -1);

      // Reset in the middle of a drain, then a clean frame.
      new_weights(3);
      run_frame(IN-1, -1, 100, 100, 4);
      new_weights(3);
      run_frame(IN-1, -1, 100, 70, -1);

      // Random framing and handshake mixes.
      for (int f = 0; f < 4; f++) begin
         case ($urandom_range(0, 2))
            0:       lp = IN-1;
            1:       lp = $urandom_range(0, IN-2);
            default: lp = IN;
         endcase
         new_weights($urandom_range(1, 3));
         run_frame(lp, -1, $urandom_range(40, 100), $urandom_range(20, 100), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
